// File: rtl/oam_dma.sv
// OAM DMA engine: copies LEN bytes from page {src_page, 00} to DEST_BASE,
// one byte per CYCLES_PER_BYTE clocks after a one-slot setup period.
module oam_dma #(
    parameter int          LEN             = 160,
    parameter int          CYCLES_PER_BYTE = 4,
    parameter logic [15:0] DEST_BASE       = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  src_page,
    output logic [15:0] r_addr,
    input  logic [7:0]  r_data,
    output logic        wen,
    output logic [15:0] w_addr,
    output logic [7:0]  w_data,
    output logic        busy,
    output logic        done
);

    localparam int            SW        = $clog2(CYCLES_PER_BYTE);
    localparam logic [SW-1:0] SLOT_LAST = SW'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0]    IDX_LAST  = 8'(LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        COPY
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [7:0]    src_q;
    logic [7:0]    idx;
    logic [7:0]    data_q;
    logic [SW-1:0] slot;
    logic          slot_end;
    logic          last_write;

    assign slot_end = (slot == SLOT_LAST);

    always_comb begin
        state_n    = state;
        wen        = 1'b0;
        r_addr     = 16'h0000;
        w_addr     = 16'h0000;
        w_data     = 8'h00;
        busy       = 1'b0;
        last_write = 1'b0;
        case (state)
            IDLE: begin
                state_n = IDLE;
            end
            SETUP: begin
                busy   = 1'b1;
                r_addr = {src_q, 8'h00};
                w_addr = DEST_BASE + {8'h00, idx};
                w_data = data_q;
                if (slot_end) begin
                    state_n = COPY;
                end
            end
            COPY: begin
                busy   = 1'b1;
                r_addr = {src_q, idx};
                w_addr = DEST_BASE + {8'h00, idx};
                w_data = data_q;
                if (slot_end) begin
                    wen = 1'b1;
                    if (idx == IDX_LAST) begin
                        state_n    = IDLE;
                        last_write = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // A new start overrides whatever is in flight, even the final write cycle
        if (start) begin
            state_n = SETUP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            done  <= last_write && !start;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= 8'h00;
            idx    <= 8'h00;
            slot   <= '0;
            data_q <= 8'h00;
        end else if (start) begin
            src_q <= src_page;
            idx   <= 8'h00;
            slot  <= '0;
        end else begin
            case (state)
                SETUP: begin
                    slot <= slot_end ? '0 : slot + 1'b1;
                end
                COPY: begin
                    // Capture early so later memory changes within the slot are ignored
                    if (slot == '0) begin
                        data_q <= r_data;
                    end
                    if (slot_end) begin
                        slot <= '0;
                        if (idx != IDX_LAST) begin
                            idx <= idx + 8'd1;
                        end
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
                default: begin
                    slot <= slot;
                end
            endcase
        end
    end

endmodule

// File: doc/oam_dma.md
# oam_dma

OAM DMA engine for the SM83 system. It acts as a bus initiator on the same split read/write memory port that memory models expose: combinational read, synchronous write. On a start strobe it copies LEN bytes from page `{src_page, 8'h00}` to DEST_BASE, at one byte per CYCLES_PER_BYTE clocks, which mirrors hardware M-cycle pacing. It sits between the CPU's DMA register write and the memory/OAM bus, and reports busy so the arbiter can lock the CPU off the bus.

## Interface
Parameters:
- LEN, 160, number of bytes per transfer (1..256)
- CYCLES_PER_BYTE, 4, clocks per byte slot and per setup slot (>= 2)
- DEST_BASE, 16'hFE00, destination base address (addr_t)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle strobe; latch src_page and begin (or restart) a transfer
- src_page  in  8  source high byte; source byte i is at `{src_page, i[7:0]}`
- r_addr  out  addr_t(16)  memory read address
- r_data  in  data_t(8)  memory read data, combinational from r_addr in the same cycle
- wen  out  1  memory write enable, one cycle per byte
- w_addr  out  addr_t(16)  memory write address
- w_data  out  data_t(8)  memory write data
- busy  out  1  transfer in progress (SETUP or COPY)
- done  out  1  one-cycle pulse when a transfer completes normally

## Operation
- State registers: state, src_q[7:0], idx[7:0], slot counter (clog2(CYCLES_PER_BYTE) bits), data_q[7:0].
- **IDLE**
  - busy=0, wen=0, r_addr=0, w_addr=0, w_data=0.
  - On start: src_q<=src_page, idx<=0, slot<=0, go to SETUP.
- **SETUP**
  - Lasts exactly CYCLES_PER_BYTE cycles.
  - No memory traffic: wen=0, r_addr=`{src_q, 8'h00}`.
  - Then go to COPY with slot=0.
- **COPY**
  - Each byte occupies one slot of CYCLES_PER_BYTE cycles.
  - r_addr=`{src_q, idx}` and w_addr=DEST_BASE+idx throughout (16-bit add, wrap ignored).
  - slot==0: data_q<=r_data.
  - slot==CYCLES_PER_BYTE-1: wen=1, w_data=data_q. Then if idx==LEN-1, go to IDLE and pulse done in the following cycle; otherwise idx<=idx+1, slot<=0.
  - wen=0 in all other cycles. w_data=data_q whenever busy.
- **Restart:** start in any state, including the final write cycle, has priority.
  - Next state is SETUP with the new src_q and idx=0.
  - The aborted transfer gets no done pulse. Bytes already written remain.
  - A wen in the start cycle itself still occurs.
- **start and rst together:** rst wins; the transfer is not accepted.
- **Reset:** state=IDLE, idx=0, slot=0, src_q=0, data_q=0, done=0.
  - All outputs are 0 in the cycle after rst is sampled high.
  - Reset mid-transfer produces no further wen and no done.
- **Overlapping regions:** no special handling; src_page=0xFE reads and writes the same byte within one slot, so contents are preserved.

## Timing
Let C=CYCLES_PER_BYTE. Start is sampled at rising edge T.
- busy rises at T+1 and stays high for C*(LEN+1) cycles.
- SETUP covers cycles T+1..T+C.
- Byte i slot covers cycles T+1+C*(i+1) .. T+C*(i+2).
  - r_data is captured in the first cycle of the slot.
  - wen is asserted in the last cycle: T+C*(i+2).
- The last wen is at T+C*(LEN+1). done is high for exactly one cycle at T+C*(LEN+1)+1, with busy=0 in that cycle.
- Defaults (C=4, LEN=160): 160 wen pulses spaced 4 cycles apart; done at T+645.
- data_q is registered: the memory value at the slot's first cycle is written, even if memory changes later in the slot.
- Back-to-back operation: start may be asserted in the done cycle; busy rises again on the next cycle.

## Test plan
- **Basic copy.** Preload mem[0xC000+i]=i^0x5A for i=0..159; pulse start with src_page=0xC0 at cycle T.
  - busy rises at T+1.
  - Exactly 160 wen pulses, at T+8, T+12, …, T+644.
  - Afterwards mem[0xFE00+i]=i^0x5A.
  - Single done pulse at T+645; busy=0 there.
- **Restart mid-transfer.** After 50 writes from 0xC0, pulse start with src_page=0xD0 (mem[0xD000+i]=~i).
  - First write from 0xD0 occurs C*2 cycles after the restart.
  - Final OAM contents are ~i for all 160 bytes.
  - Exactly one done pulse.
- **Reset mid-transfer.** Assert rst for 1 cycle after 80 writes.
  - Next cycle: busy=0, wen=0, r_addr=0.
  - No done pulse.
  - mem[0xFE50..0xFE9F] retain their prior values.
- **Fast pacing.** CYCLES_PER_BYTE=2 with the same stimulus as the basic copy.
  - wen at T+4, T+6, …, T+322.
  - done at T+323.
- **Start held / start with rst.**
  - start held high for 3 cycles: the transfer begins from the last high cycle, so done is at (last high cycle)+645.
  - start and rst high together: busy stays 0.
- **Self-copy.** src_page=0xFE with OAM prefilled with a pattern: OAM is unchanged and done is at T+645.
